// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the fifo_ip read-side burst controller.
// State encoding and a constant-safe clog2 used for pointer sizing.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    IDLE     = 2'd1,
    BURST    = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small synchronous output buffer between the FIFO read port and the stream.
// Pointers wrap naturally; occ carries one extra bit to tell full from empty.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [W-1:0]          din_i,
  input  logic                  pop_i,
  output logic [W-1:0]          dout_o,
  output logic [clog2(DEPTH):0] occ_o
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   occ_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (occ_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      occ_q <= occ_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign dout_o = mem_q[rd_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains fifo_ip in bursts and re-emits words as a valid/ready stream.
// Reads are credit-limited so the output buffer can never overflow.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_valid,
  input  logic              fifo_empty,
  input  logic              fifo_underflow,
  input  logic [CNT_W-1:0]  fifo_rd_data_count,
  input  logic              fifo_rd_rst_busy,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              underflow_err,
  input  logic              err_clr
);

  localparam int OW = clog2(SKID_DEPTH) + 1;
  localparam int TW = clog2(TIMEOUT + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t BL = cnt_t'(BURST_LEN);

  state_e        state_q;
  cnt_t          blen_q;
  cnt_t          issued_q;
  logic [TW-1:0] timer_q;
  logic          inflight_q;
  logic          last_if_q;
  logic          err_q;
  logic          busy_q;

  logic [OW-1:0] occ;
  logic [OW-1:0] occ_nx;
  logic [DATA_W:0] buf_dout;
  cnt_t          cnt;
  cnt_t          blen_start;
  logic          credit_ok;
  logic          is_last;
  logic          rd_en;
  logic          go_burst;
  logic          push;
  logic          pop;
  logic          has_data;
  logic          nxt_active;

  assign cnt       = fifo_rd_data_count;
  assign credit_ok = (occ + OW'(inflight_q)) < OW'(SKID_DEPTH);
  assign is_last   = issued_q == blen_q - cnt_t'(1);

  assign rd_en = (state_q == BURST) && !fifo_empty
              && !fifo_rd_rst_busy && credit_ok;

  assign go_burst = (state_q == IDLE) && !fifo_rd_rst_busy
                 && ((cnt >= BL)
                  || (timer_q == TW'(TIMEOUT) && !fifo_empty));

  // A lagging count of 0 with the FIFO non-empty still yields one safe read.
  assign blen_start = (cnt >= BL)     ? BL :
                      (cnt == '0)     ? cnt_t'(1) : cnt;

  assign has_data = occ != '0;
  assign push     = fifo_valid && !fifo_rd_rst_busy;
  assign pop      = has_data && m_ready;
  assign occ_nx   = fifo_rd_rst_busy ? '0
                  : occ + OW'(push) - OW'(pop);

  assign nxt_active = fifo_rd_rst_busy || go_burst
                   || (state_q == BURST && !(rd_en && is_last));

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_WAIT;
      blen_q     <= '0;
      issued_q   <= '0;
      timer_q    <= '0;
      inflight_q <= 1'b0;
      last_if_q  <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      last_if_q  <= rd_en && is_last;
      busy_q     <= nxt_active || (occ_nx != '0);
      if (fifo_underflow || (fifo_valid && !inflight_q))
        err_q <= 1'b1;
      else if (err_clr)
        err_q <= 1'b0;
      if (fifo_rd_rst_busy) begin
        state_q  <= RST_WAIT;
        issued_q <= '0;
        timer_q  <= '0;
      end else begin
        unique case (state_q)
          RST_WAIT: state_q <= IDLE;
          IDLE: begin
            if (go_burst) begin
              state_q  <= BURST;
              blen_q   <= blen_start;
              issued_q <= '0;
              timer_q  <= '0;
            end else if (fifo_empty) begin
              timer_q <= '0;
            end else if (timer_q != TW'(TIMEOUT)) begin
              timer_q <= timer_q + TW'(1);
            end
          end
          BURST: begin
            timer_q <= '0;
            if (rd_en) begin
              issued_q <= issued_q + cnt_t'(1);
              if (is_last) state_q <= IDLE;
            end
          end
          default: state_q <= RST_WAIT;
        endcase
      end
    end
  end

  fifo_rd_skid_buf #(
    .DEPTH (SKID_DEPTH),
    .W     (DATA_W + 1)
  ) u_buf (
    .clk     (rd_clk),
    .rst_n   (rst_n),
    .flush_i (fifo_rd_rst_busy),
    .push_i  (push),
    .din_i   ({last_if_q, fifo_dout}),
    .pop_i   (pop),
    .dout_o  (buf_dout),
    .occ_o   (occ)
  );

  assign fifo_rd_en    = rd_en;
  assign m_valid       = has_data;
  assign m_data        = has_data ? buf_dout[DATA_W-1:0] : '0;
  assign m_last        = has_data && buf_dout[DATA_W];
  assign busy          = busy_q;
  assign underflow_err = err_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a queue-based fifo_ip model.
// Expected beats come from burst segmentation of each written batch.
module tb_fifo_burst_reader;

  localparam int BL = 16;

  logic       rd_clk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout = '0;
  logic       fifo_valid = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_underflow = 1'b0;
  logic [7:0] fifo_rd_data_count = '0;
  logic       fifo_rd_rst_busy = 1'b1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b0;
  logic       busy;
  logic       underflow_err;
  logic       err_clr = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic [7:0] fq[$];
  exp_t       expq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_rd = -1;
  int first_mv = -1;
  int rd_cnt = 0;
  int rmode = 0;
  logic take = 1'b0;

  fifo_burst_reader dut (
    .rd_clk             (rd_clk),
    .rst_n              (rst_n),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_dout          (fifo_dout),
    .fifo_valid         (fifo_valid),
    .fifo_empty         (fifo_empty),
    .fifo_underflow     (fifo_underflow),
    .fifo_rd_data_count (fifo_rd_data_count),
    .fifo_rd_rst_busy   (fifo_rd_rst_busy),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_last             (m_last),
    .m_ready            (m_ready),
    .busy               (busy),
    .underflow_err      (underflow_err),
    .err_clr            (err_clr)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void upd_flags();
    fifo_empty = (fq.size() == 0);
    fifo_rd_data_count = (fq.size() > 255) ? 8'd255 : 8'(fq.size());
  endfunction

  // fifo_ip model: standard mode, data one cycle after the read enable
  always @(negedge rd_clk) take = fifo_rd_en;
  always @(posedge rd_clk) begin
    cyc++;
    #1;
    if (take && fq.size() > 0) begin
      fifo_dout  = fq.pop_front();
      fifo_valid = 1'b1;
    end else begin
      fifo_dout  = 8'($urandom);
      fifo_valid = 1'b0;
    end
    upd_flags();
  end

  always @(negedge rd_clk) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && first_mv < 0) first_mv = cyc;
  end

  initial begin
    forever begin
      @(posedge rd_clk);
      #1;
      case (rmode)
        1: m_ready = ~m_ready;
        2: m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks hold on stall
  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;
  always @(negedge rd_clk) begin
    if (rst_n) begin
      if (hold_v && !fifo_rd_rst_busy) begin
        checks++;
        if (!m_valid || m_data !== hold_d || m_last !== hold_l) begin
          errors++;
          $display("FAIL hold: got v%0b %0h/%0b expected %0h/%0b",
                   m_valid, m_data, m_last, hold_d, hold_l);
        end
      end
      hold_v = 1'b0;
      if (m_valid && m_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL beat: got %0h/%0b expected none", m_data, m_last);
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (m_data !== e.d || m_last !== e.l) begin
            errors++;
            $display("FAIL beat: got %0h/%0b expected %0h/%0b",
                     m_data, m_last, e.d, e.l);
          end
        end
      end else if (m_valid) begin
        hold_v = 1'b1;
        hold_d = m_data;
        hold_l = m_last;
      end
    end
  end

  // A batch written at once drains as full bursts, then one short tail.
  task automatic write_batch(input int n, input bit fe_pat);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = fe_pat ? 8'(8'hFE - i) : 8'($urandom);
      e.l = ((i + 1) % BL == 0) || (i == n - 1);
      fq.push_back(e.d);
      expq.push_back(e);
    end
    upd_flags();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_drain(input int lim, input string nm);
    int t;
    t = 0;
    while ((expq.size() != 0 || fq.size() != 0 || busy) && t < lim) begin
      tick(1);
      t++;
    end
    checks++;
    if (t >= lim) begin
      errors++;
      $display("FAIL %s: got %0d pending expected 0", nm, expq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int wcyc;
    upd_flags();
    // T1: reset values, then RST_WAIT held by rd_rst_busy
    @(negedge rd_clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", underflow_err, 0);
    tick(1);
    rst_n = 1'b1;
    write_batch(16, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge rd_clk);
      chk("t1_rd_en", fifo_rd_en, 0);
    end
    chk("t1_busy", busy, 1);
    tick(1);
    first_rd = -1;
    first_mv = -1;
    fifo_rd_rst_busy = 1'b0;
    // T2: 16-word burst, 0xFE first, last on 0xEF
    wait_drain(300, "t2_drain");
    chk("t2_latency", 32'(first_mv - first_rd), 2);
    // T3: short batch starts only after the idle timeout
    tick(3);
    first_rd = -1;
    write_batch(3, 1'b0);
    wcyc = cyc;
    t = 0;
    while (first_rd < 0 && t < 200) begin
      tick(1);
      t++;
    end
    chk("t3_timeout", 32'((first_rd - wcyc >= 64) &&
                          (first_rd - wcyc <= 70)), 1);
    wait_drain(300, "t3_drain");
    tick(2);
    chk("t3_busy", busy, 0);
    chk("t3_m_valid", m_valid, 0);
    // T4: 40 words with m_ready toggling
    rmode = 1;
    write_batch(40, 1'b0);
    wait_drain(2000, "t4_drain");
    // Random batches with random backpressure
    rmode = 2;
    for (int r = 0; r < 6; r++) begin
      write_batch($urandom_range(1, 50), 1'b0);
      wait_drain(3000, "rnd_drain");
      tick(2);
    end
    // T5: rd_rst_busy after 5 reads
    rmode = 0;
    tick(2);
    write_batch(20, 1'b0);
    rd_cnt = 0;
    t = 0;
    while (rd_cnt < 5 && t < 200) begin
      @(negedge rd_clk);
      t++;
    end
    chk("t5_reads", 32'(rd_cnt), 5);
    @(posedge rd_clk);
    #1;
    fifo_rd_rst_busy = 1'b1;
    @(negedge rd_clk);
    chk("t5_rd_en", fifo_rd_en, 0);
    @(negedge rd_clk);
    chk("t5_m_valid", m_valid, 0);
    chk("t5_busy", busy, 1);
    tick(2);
    fq.delete();
    expq.delete();
    upd_flags();
    fifo_rd_rst_busy = 1'b0;
    tick(3);
    chk("t5_idle", busy, 0);
    chk("t5_empty", m_valid, 0);
    // T6: sticky underflow flag; set wins over clear
    chk("t6_pre", underflow_err, 0);
    fifo_underflow = 1'b1;
    tick(1);
    fifo_underflow = 1'b0;
    chk("t6_set", underflow_err, 1);
    tick(5);
    chk("t6_sticky", underflow_err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t6_clr", underflow_err, 0);
    fifo_underflow = 1'b1;
    err_clr = 1'b1;
    tick(1);
    fifo_underflow = 1'b0;
    err_clr = 1'b0;
    chk("t6_set_wins", underflow_err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t6_clr2", underflow_err, 0);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
